// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg
// Shared definitions for the instruction-memory boot loader: memory geometry,
// the loader FSM state encoding and the high-byte reserved-bit mask.
package inst_loader_pkg;

    localparam int INST_W = 13;                // instruction width in bits
    localparam int ADDR_W = 4;                 // instruction memory address width
    localparam int DEPTH  = 2 ** ADDR_W;       // memory depth in words

    // Largest legal header value, in the same width as the incoming byte.
    localparam logic [7:0] DEPTH_BYTE = 8'(DEPTH);

    // Bits [7:5] of a high byte must be zero; inst is only 13 bits wide.
    localparam logic [2:0] HI_RSVD_MASK = 3'b111;

    typedef enum logic [2:0] {
        IDLE,   // waiting for start, CPU owns the memory
        HDR,    // expecting the word-count header
        LO,     // expecting inst[7:0]
        HI,     // expecting {3'b000, inst[12:8]}
        WR,     // one-cycle memory write strobe
        CHK,    // expecting the XOR checksum
        DONE,   // load good, CPU released
        ERR     // load aborted, CPU kept on hold
    } loaderState_e;

endpackage

// File: rtl/inst_loader_if.sv
// inst_loader_if
// Bundles the loader's control, byte-stream and memory-write signals.
//   start            load request pulse
//   rx_data/valid    incoming byte stream; rx_ready is the loader's accept
//   mem_wr/addr/data instruction memory write port
//   cpu_hold         CPU stalled while the loader owns the memory
//   done / err       load outcome
// Modport master: host side (drives start and the byte stream).
// Modport slave : loader side (drives ready, memory port and status).
interface inst_loader_if;
    import inst_loader_pkg::*;

    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_data;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, mem_wr, mem_addr, mem_data, cpu_hold, done, err
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, mem_wr, mem_addr, mem_data, cpu_hold, done, err
    );

endinterface

// File: rtl/inst_loader.sv
// inst_loader
// Byte-serial boot loader that fills the instruction memory before the CPU
// runs. Frame: header N (1..DEPTH), N pairs of {low, high} instruction bytes,
// then an XOR checksum over header and data bytes. Each word is written with
// a single-cycle mem_wr strobe; the CPU is held off the memory while loading
// and stays held if the load fails.
// Ports:
//   CLK   system clock, rising edge
//   RSTn  asynchronous active-low reset
//   bus   inst_loader_if.slave (start, rx stream, memory port, status)
module inst_loader
    import inst_loader_pkg::*;
(
    input  logic CLK,
    input  logic RSTn,
    inst_loader_if.slave bus
);

    loaderState_e      stateReg, stateNext;
    logic [7:0]        chkReg, chkNext;
    logic [ADDR_W:0]   remainingReg, remainingNext;   // holds up to DEPTH
    logic [ADDR_W-1:0] addrReg, addrNext;
    logic [INST_W-1:0] dataReg, dataNext;
    logic              rxReady;
    logic              xfer;

    // Handshake and strobes are decoded from the state register only.
    assign rxReady      = (stateReg == HDR) || (stateReg == LO) ||
                          (stateReg == HI)  || (stateReg == CHK);
    assign xfer         = bus.rx_valid && rxReady;

    assign bus.rx_ready = rxReady;
    assign bus.mem_wr   = (stateReg == WR);
    assign bus.cpu_hold = (stateReg != IDLE) && (stateReg != DONE);
    assign bus.done     = (stateReg == DONE);
    assign bus.err      = (stateReg == ERR);
    assign bus.mem_addr = addrReg;
    assign bus.mem_data = dataReg;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stateReg     <= IDLE;
            chkReg       <= '0;
            remainingReg <= '0;
            addrReg      <= '0;
            dataReg      <= '0;
        end else begin
            stateReg     <= stateNext;
            chkReg       <= chkNext;
            remainingReg <= remainingNext;
            addrReg      <= addrNext;
            dataReg      <= dataNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        chkNext       = chkReg;
        remainingNext = remainingReg;
        addrNext      = addrReg;
        dataNext      = dataReg;

        case (stateReg)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    stateNext = HDR;
                    addrNext  = '0;
                    chkNext   = '0;
                end
            end
            HDR: begin
                if (xfer) begin
                    chkNext = chkReg ^ bus.rx_data;
                    if (bus.rx_data == 8'd0 || bus.rx_data > DEPTH_BYTE) begin
                        stateNext = ERR;
                    end else begin
                        remainingNext = bus.rx_data[ADDR_W:0];
                        stateNext     = LO;
                    end
                end
            end
            LO: begin
                if (xfer) begin
                    dataNext[7:0] = bus.rx_data;
                    chkNext       = chkReg ^ bus.rx_data;
                    stateNext     = HI;
                end
            end
            HI: begin
                if (xfer) begin
                    if ((bus.rx_data[7:5] & HI_RSVD_MASK) != 3'b000) begin
                        stateNext = ERR;
                    end else begin
                        dataNext[INST_W-1:8] = bus.rx_data[INST_W-9:0];
                        chkNext              = chkReg ^ bus.rx_data;
                        stateNext            = WR;
                    end
                end
            end
            WR: begin
                // Memory captures on the edge that leaves WR; the address
                // advances on that same edge and wraps naturally at DEPTH.
                addrNext      = addrReg + 1'b1;
                remainingNext = remainingReg - 1'b1;
                stateNext     = (remainingReg == (ADDR_W+1)'(1)) ? CHK : LO;
            end
            CHK: begin
                if (xfer) begin
                    stateNext = (bus.rx_data == chkReg) ? DONE : ERR;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader
// Self-checking bench for inst_loader. Expected memory writes are queued as
// each frame is built and popped by a monitor whenever mem_wr is seen.
module tb_inst_loader;
    import inst_loader_pkg::*;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    inst_loader_if bus ();

    inst_loader dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    int passCount  = 0;
    int totalCount = 0;

    logic [ADDR_W+INST_W-1:0] expQ[$];     // {addr, data} of expected writes
    logic [7:0]               frame[0:63];
    int                       frameLen;
    logic [INST_W-1:0]        prog[0:15];

    // Write monitor: every mem_wr cycle must match the next expected write.
    always @(negedge CLK) begin
        logic [ADDR_W+INST_W-1:0] exp;
        if (RSTn && bus.mem_wr === 1'b1) begin
            totalCount++;
            if (expQ.size() == 0) begin
                $display("FAIL write_unexpected: got addr=%0h data=%04h, required no write",
                         bus.mem_addr, bus.mem_data);
            end else begin
                exp = expQ.pop_front();
                if ({bus.mem_addr, bus.mem_data} !== exp) begin
                    $display("FAIL write_value: got addr=%0h data=%04h, required addr=%0h data=%04h",
                             bus.mem_addr, bus.mem_data, exp[ADDR_W+INST_W-1:INST_W], exp[INST_W-1:0]);
                end else begin
                    passCount++;
                    $display("write addr=%0h data=%04h", bus.mem_addr, bus.mem_data);
                end
            end
        end
    end

    // Frame from prog[0..n-1]: header, {lo, hi} pairs, XOR checksum.
    task automatic buildFrame(input int n);
        logic [7:0] chk;
        logic [7:0] hdr;
        hdr      = 8'(n);
        chk      = hdr;
        frame[0] = hdr;
        for (int i = 0; i < n; i++) begin
            frame[1 + 2*i] = prog[i][7:0];
            frame[2 + 2*i] = {3'b000, prog[i][INST_W-1:8]};
            chk = chk ^ frame[1 + 2*i] ^ frame[2 + 2*i];
        end
        frame[1 + 2*n] = chk;
        frameLen       = 2 + 2*n;
    endtask

    task automatic pushExpected(input int n);
        for (int i = 0; i < n; i++) begin
            expQ.push_back({ADDR_W'(i % DEPTH), prog[i]});
        end
    endtask

    task automatic loadProgram3();
        prog[0] = 13'h109B;
        prog[1] = 13'h0424;
        prog[2] = 13'h1C0C;
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
    endtask

    // Offers frame bytes until all frameLen are accepted; counts clock edges.
    task automatic sendFrame(input bit randValid, input int startIdx, output int cycles);
        int idx;
        bit acc;
        idx    = 0;
        cycles = 0;
        while (idx < frameLen && cycles < 400) begin
            bus.rx_valid = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.rx_data  = bus.rx_valid ? frame[idx] : ~frame[idx];
            bus.start    = (idx == startIdx);
            acc = bus.rx_valid && bus.rx_ready;
            @(posedge CLK); #1;
            cycles++;
            if (acc) idx++;
        end
        bus.rx_valid = 1'b0;
        bus.start    = 1'b0;
        totalCount++;
        if (idx !== frameLen) $display("FAIL frame_timeout: accepted %0d bytes, required %0d", idx, frameLen);
        else passCount++;
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        RSTn = 1'b0;
        bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        #12;
        obs = {bus.rx_ready, bus.mem_wr, bus.mem_addr, bus.mem_data, bus.cpu_hold, bus.done, bus.err};
        totalCount++;
        if (obs !== '0) $display("FAIL reset_outputs: got %h, required 0", obs);
        else passCount++;
        @(posedge CLK); #1;
        RSTn = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_basic();
        int cyc;
        loadProgram3(); buildFrame(3); pushExpected(3);
        pulseStart();
        sendFrame(1'b0, -1, cyc);
        totalCount++;
        if (cyc !== 11) $display("FAIL basic_latency: got %0d cycles, required 11", cyc);
        else passCount++;
        totalCount++;
        if ({bus.done, bus.err, bus.cpu_hold, bus.mem_addr} !== {3'b100, 4'd3})
            $display("FAIL basic_status: got done/err/hold/addr=%b, required 1000011",
                     {bus.done, bus.err, bus.cpu_hold, bus.mem_addr});
        else passCount++;
        totalCount++;
        if (expQ.size() !== 0) $display("FAIL basic_writes_left: got %0d, required 0", expQ.size());
        else passCount++;
    endtask

    task automatic test_bad_checksum();
        int cyc;
        loadProgram3(); buildFrame(3); pushExpected(3);
        frame[7] = 8'hB9;
        pulseStart();
        sendFrame(1'b0, -1, cyc);
        totalCount++;
        if ({bus.done, bus.err, bus.cpu_hold} !== 3'b011)
            $display("FAIL badchk_status: got done/err/hold=%b, required 011", {bus.done, bus.err, bus.cpu_hold});
        else passCount++;
        totalCount++;
        if (expQ.size() !== 0) $display("FAIL badchk_writes_left: got %0d, required 0", expQ.size());
        else passCount++;
    endtask

    task automatic test_header_edges();
        int cyc;
        logic [7:0] hdrs[2];
        hdrs[0] = 8'h00;
        hdrs[1] = 8'h11;
        for (int h = 0; h < 2; h++) begin
            frame[0] = hdrs[h];
            frameLen = 1;
            pulseStart();
            sendFrame(1'b0, -1, cyc);
            repeat (3) @(posedge CLK);
            #1;
            totalCount++;
            if ({bus.done, bus.err, bus.cpu_hold, bus.rx_ready} !== 4'b0110)
                $display("FAIL header_%02h_status: got done/err/hold/ready=%b, required 0110",
                         hdrs[h], {bus.done, bus.err, bus.cpu_hold, bus.rx_ready});
            else passCount++;
        end
    endtask

    task automatic test_header_16();
        int cyc;
        for (int i = 0; i < 16; i++) prog[i] = 13'(i * 'h2A7 + 'h055);
        buildFrame(16); pushExpected(16);
        pulseStart();
        sendFrame(1'b0, -1, cyc);
        totalCount++;
        if (cyc !== 50) $display("FAIL hdr16_latency: got %0d cycles, required 50", cyc);
        else passCount++;
        totalCount++;
        if ({bus.done, bus.err, bus.cpu_hold, bus.mem_addr} !== {3'b100, 4'd0})
            $display("FAIL hdr16_status: got done/err/hold/addr=%b, required 1000000",
                     {bus.done, bus.err, bus.cpu_hold, bus.mem_addr});
        else passCount++;
        totalCount++;
        if (expQ.size() !== 0) $display("FAIL hdr16_writes_left: got %0d, required 0", expQ.size());
        else passCount++;
    endtask

    task automatic test_reserved_bits();
        int cyc;
        loadProgram3(); buildFrame(3);
        frame[4] = 8'h20;
        frameLen = 5;
        pushExpected(1);
        pulseStart();
        sendFrame(1'b0, -1, cyc);
        repeat (3) @(posedge CLK);
        #1;
        totalCount++;
        if ({bus.done, bus.err, bus.cpu_hold} !== 3'b011)
            $display("FAIL rsvd_status: got done/err/hold=%b, required 011", {bus.done, bus.err, bus.cpu_hold});
        else passCount++;
        totalCount++;
        if (expQ.size() !== 0) $display("FAIL rsvd_writes_left: got %0d, required 0", expQ.size());
        else passCount++;
    endtask

    task automatic test_random_valid();
        int cyc;
        for (int r = 0; r < 3; r++) begin
            loadProgram3(); buildFrame(3); pushExpected(3);
            pulseStart();
            sendFrame(1'b1, -1, cyc);
            totalCount++;
            if ({bus.done, bus.err, bus.cpu_hold, bus.mem_addr} !== {3'b100, 4'd3})
                $display("FAIL randvalid_status: got done/err/hold/addr=%b, required 1000011",
                         {bus.done, bus.err, bus.cpu_hold, bus.mem_addr});
            else passCount++;
            totalCount++;
            if (expQ.size() !== 0) $display("FAIL randvalid_writes_left: got %0d, required 0", expQ.size());
            else passCount++;
        end
    endtask

    task automatic test_reset_mid_load();
        int cyc;
        logic [21:0] obs;
        loadProgram3(); buildFrame(3);
        frameLen = 2;                       // header and first low byte only
        pulseStart();
        sendFrame(1'b0, -1, cyc);
        totalCount++;
        if ({bus.rx_ready, bus.cpu_hold, bus.mem_data[7:0]} !== {2'b11, 8'h9B})
            $display("FAIL midreset_in_hi: got ready/hold/data_lo=%h, required 39b",
                     {bus.rx_ready, bus.cpu_hold, bus.mem_data[7:0]});
        else passCount++;
        #2 RSTn = 1'b0;
        #1;
        obs = {bus.rx_ready, bus.mem_wr, bus.mem_addr, bus.mem_data, bus.cpu_hold, bus.done, bus.err};
        totalCount++;
        if (obs !== '0) $display("FAIL midreset_outputs: got %h, required 0", obs);
        else passCount++;
        @(posedge CLK); #1;
        RSTn = 1'b1;
        @(posedge CLK); #1;
        test_basic();
    endtask

    task automatic test_start_ignored();
        int cyc;
        loadProgram3(); buildFrame(3); pushExpected(3);
        pulseStart();
        sendFrame(1'b0, 1, cyc);            // start asserted while in LO
        totalCount++;
        if (cyc !== 11) $display("FAIL startign_latency: got %0d cycles, required 11", cyc);
        else passCount++;
        totalCount++;
        if ({bus.done, bus.err, bus.cpu_hold, bus.mem_addr} !== {3'b100, 4'd3})
            $display("FAIL startign_status: got done/err/hold/addr=%b, required 1000011",
                     {bus.done, bus.err, bus.cpu_hold, bus.mem_addr});
        else passCount++;
        totalCount++;
        if (expQ.size() !== 0) $display("FAIL startign_writes_left: got %0d, required 0", expQ.size());
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_header_edges();
        test_header_16();
        test_reserved_bits();
        test_random_valid();
        test_reset_mid_load();
        test_start_ignored();
        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
